// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/address out, word/ack back.
// The master side is the fetch unit, the slave side is instruction memory.
interface instr_fetch_if #(
   parameter int PC_W = 64
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch: PC, imem req/ack handshake, stall hold,
// branch redirect, and the opcode slice feeding the control decoder.
module instr_fetch #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   instr_fetch_if.master   imem,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic [31:0]     instr,
   output logic [10:0]     opcode,
   output logic [PC_W-1:0] pc_out,
   output logic            instr_valid,
   output logic [31:0]     fetch_count
);
   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [PC_W-1:0] STEP  = PC_W'(4);
   localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

   logic [1:0]      state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] next_pc;
   logic            req_q;
   logic            fire;
   logic            retire;

   assign fire   = (state == REQ) && imem.imem_ack;
   assign retire = (state == HOLD) && !stall;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;
   assign opcode         = instr[31:21];

   // Successor of the retiring instruction: word-aligned target or pc+4
   always_comb begin
      next_pc = pc + STEP;
      if (branch_taken)
         next_pc = branch_target & ALIGN;
   end

   // Fetch sequencer: state, program counter and request strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_PC;
         req_q <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (imem.imem_ack) begin
                  state <= HOLD;
                  req_q <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state <= REQ;
                  req_q <= 1'b1;
                  pc    <= next_pc;
               end
            end
            default: begin
               state <= BOOT;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   // Capture the returned word and track whether it is still current
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr       <= 32'h0;
         pc_out      <= RESET_PC;
         instr_valid <= 1'b0;
      end else if (fire) begin
         instr       <= imem.imem_rdata;
         pc_out      <= pc;
         instr_valid <= 1'b1;
      end else if (retire) begin
         instr_valid <= 1'b0;
      end
   end

   // Count instructions as they are advanced past
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_count <= 32'h0;
      else if (retire)
         fetch_count <= fetch_count + 32'd1;
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed plan items plus a randomized run,
// all checked against a transaction-level reference model.
module tb_instr_fetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        stall;
   logic        br;
   logic [63:0] tgt;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] pc_out;
   logic        valid;
   logic [31:0] fcnt;

   logic        rst_w;
   logic        stall_w;
   logic        br_w;
   logic [63:0] tgt_w;
   logic [31:0] instr_w;
   logic [10:0] opcode_w;
   logic [63:0] pc_out_w;
   logic        valid_w;
   logic [31:0] fcnt_w;

   instr_fetch_if #(.PC_W(64)) bus ();
   instr_fetch_if #(.PC_W(64)) bw ();

   instr_fetch #(.PC_W(64), .RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst), .imem(bus),
      .stall(stall), .branch_taken(br), .branch_target(tgt),
      .instr(instr), .opcode(opcode), .pc_out(pc_out),
      .instr_valid(valid), .fetch_count(fcnt)
   );

   instr_fetch #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst_w), .imem(bw),
      .stall(stall_w), .branch_taken(br_w), .branch_target(tgt_w),
      .instr(instr_w), .opcode(opcode_w), .pc_out(pc_out_w),
      .instr_valid(valid_w), .fetch_count(fcnt_w)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(logic [63:0] a);
      case (a)
         64'd0:   mem_word = 32'hF840_0000;
         64'd4:   mem_word = 32'h8B02_0020;
         64'd8:   mem_word = 32'hD280_0000;
         default: mem_word = (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // reference model: what the fetch unit should be showing right now
   bit          m_boot;
   bit          m_req;
   bit          m_valid;
   logic [63:0] m_pc;
   logic [63:0] m_pcout;
   logic [31:0] m_instr;
   logic [31:0] m_cnt;

   // memory responder knobs
   int ack_wait;
   int ack_ctr;
   bit spur;
   bit rnd_wait;

   task automatic model_reset();
      m_boot  = 1'b1;
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_pc    = 64'h0;
      m_pcout = 64'h0;
      m_instr = 32'h0;
      m_cnt   = 32'h0;
      ack_ctr = 0;
   endtask

   task automatic compare();
      logic [31:0] mi;
      mi = m_instr;
      chk("req", bus.imem_req, m_req);
      chk("addr", bus.imem_addr, m_pc);
      chk("valid", valid, m_valid);
      chk("instr", instr, m_instr);
      chk("opcode", opcode, mi[31:21]);
      chk("pc_out", pc_out, m_pcout);
      chk("count", fcnt, m_cnt);
   endtask

   // drive memory for the coming edge, predict its effect, check after it
   task automatic step();
      logic [31:0] w;
      w = $urandom;
      if (rst) begin
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = w;
      end else if (m_req) begin
         if (ack_ctr >= ack_wait) begin
            w = mem_word(m_pc);
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = w;
            ack_ctr = 0;
            if (rnd_wait)
               ack_wait = $urandom_range(0, 3);
         end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = w;
            ack_ctr++;
         end
      end else begin
         bus.imem_ack   = spur && ($urandom_range(0, 2) == 0);
         bus.imem_rdata = w;
      end

      if (rst) begin
         model_reset();
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_req  = 1'b1;
      end else if (m_req) begin
         if (bus.imem_ack) begin
            m_instr = w;
            m_pcout = m_pc;
            m_valid = 1'b1;
            m_req   = 1'b0;
         end
      end else if (m_valid && !stall) begin
         m_cnt   = m_cnt + 32'd1;
         m_valid = 1'b0;
         m_pc    = br ? (tgt & ~64'h3) : m_pc + 64'd4;
         m_req   = 1'b1;
      end

      @(negedge clk);
      compare();
   endtask

   logic [10:0] seq_op [3];

   initial begin
      seq_op = '{11'h7C2, 11'h458, 11'h694};
      rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 64'h0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
      rst_w = 1'b1; stall_w = 1'b0; br_w = 1'b0; tgt_w = 64'h0;
      bw.imem_ack = 1'b0; bw.imem_rdata = 32'h0;
      ack_wait = 0; spur = 1'b0; rnd_wait = 1'b0;
      model_reset();

      // reset and boot
      @(negedge clk);
      compare();
      step();
      step();
      rst = 1'b0;
      chk("boot_req", bus.imem_req, 1'b0);
      step();
      chk("first_req", bus.imem_req, 1'b1);
      chk("first_addr", bus.imem_addr, 64'h0);

      // sequential fetch, zero-wait memory
      for (int k = 0; k < 3; k++) begin
         step();
         chk("seq_op", opcode, seq_op[k]);
         chk("seq_pc", pc_out, 64'(4 * k));
         chk("seq_valid", valid, 1'b1);
         step();
         chk("seq_gap", valid, 1'b0);
      end
      chk("seq_cnt", fcnt, 32'd3);

      // wait states then stall
      ack_wait = 3;
      stall = 1'b1;
      repeat (3) begin
         step();
         chk("wait_addr", bus.imem_addr, 64'd12);
         chk("wait_req", bus.imem_req, 1'b1);
      end
      step();
      repeat (4) begin
         step();
         chk("stall_instr", instr, mem_word(64'd12));
         chk("stall_pc", pc_out, 64'd12);
         chk("stall_valid", valid, 1'b1);
         chk("stall_cnt", fcnt, 32'd3);
      end
      stall = 1'b0;
      step();
      chk("retire_cnt", fcnt, 32'd4);

      // branch, including branch masked by stall
      ack_wait = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      repeat (5) step();
      chk("br_hold_pc", pc_out, 64'd8);
      br = 1'b1; tgt = 64'h103; stall = 1'b1;
      step();
      chk("br_stall_req", bus.imem_req, 1'b0);
      chk("br_stall_addr", bus.imem_addr, 64'd8);
      stall = 1'b0;
      step();
      chk("br_addr", bus.imem_addr, 64'h100);
      br = 1'b0;
      step();
      br = 1'b1; tgt = 64'h43; ack_wait = 100;
      step();
      br = 1'b0;
      chk("pre_rst_addr", bus.imem_addr, 64'h40);
      step();

      // reset in the middle of a fetch, ack arriving during reset
      #2 rst = 1'b1;
      #1;
      chk("async_req", bus.imem_req, 1'b0);
      chk("async_addr", bus.imem_addr, 64'h0);
      step();
      chk("rst_nocap", instr, 32'h0);
      step();
      rst = 1'b0;
      ack_wait = 0;
      step();
      chk("restart_addr", bus.imem_addr, 64'h0);
      chk("restart_req", bus.imem_req, 1'b1);

      // randomized traffic
      spur = 1'b1;
      rnd_wait = 1'b1;
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(0, 9) < 3);
         br    = ($urandom_range(0, 3) == 0);
         tgt   = ($urandom_range(0, 1) == 1) ? {32'h0, $urandom}
                                             : {$urandom, $urandom};
         step();
      end
      stall = 1'b0; br = 1'b0; spur = 1'b0;
      rst = 1'b1;

      // PC wrap-around and fetch_count wrap
      rst_w = 1'b0;
      chk("w_boot_req", bw.imem_req, 1'b0);
      @(negedge clk);
      chk("w_req", bw.imem_req, 1'b1);
      chk("w_addr", bw.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      bw.imem_ack = 1'b1;
      bw.imem_rdata = 32'hF840_0000;
      @(negedge clk);
      bw.imem_ack = 1'b0;
      chk("w_pcout", pc_out_w, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("w_valid", valid_w, 1'b1);
      chk("w_op", opcode_w, 11'h7C2);
      @(negedge clk);
      chk("w_wrap_addr", bw.imem_addr, 64'h0);
      chk("w_cnt", fcnt_w, 32'd1);
      bw.imem_ack = 1'b1;
      bw.imem_rdata = 32'h8B02_0020;
      stall_w = 1'b1;
      @(negedge clk);
      bw.imem_ack = 1'b0;
      force dut_w.fetch_count = 32'hFFFF_FFFF;
      #1 release dut_w.fetch_count;
      @(negedge clk);
      chk("w_hold_cnt", fcnt_w, 32'hFFFF_FFFF);
      stall_w = 1'b0;
      @(negedge clk);
      chk("w_cnt_wrap", fcnt_w, 32'h0);
      chk("w_next_addr", bw.imem_addr, 64'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Sequential instruction-fetch unit that drives the opcode input of the single-cycle LEGv8 control decoder. It holds the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake. It presents each fetched word, and its 11-bit opcode field, with a valid flag, then advances the PC sequentially or to a branch target supplied by the datapath.

## Interface
Parameters:
- PC_W, 64, program-counter and address width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_W  fetch address, equal to current PC
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- imem_ack  input  1  memory completion strobe, one cycle
- stall  input  1  downstream hold; freezes the current instruction
- branch_taken  input  1  redirect request (Branch AND Zero from datapath)
- branch_target  input  PC_W  redirect address
- instr  output  32  captured instruction word
- opcode  output  11  instr[31:21], feeds control decoder
- pc_out  output  PC_W  address of the instruction in instr
- instr_valid  output  1  instr/opcode/pc_out hold a valid fetched word
- fetch_count  output  32  number of instructions retired (advanced past)

## Operation
- States: BOOT, REQ, HOLD.
- Reset (async, immediate):
  - state=BOOT, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, instr=32'h0, opcode=11'h0, pc_out=RESET_PC, instr_valid=0, fetch_count=0.
- BOOT: one cycle with no request, then REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Address held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, go to HOLD.
  - No ack: remain in REQ indefinitely; there is no timeout.
- HOLD:
  - imem_req=0. Outputs frozen while stall=1.
  - When stall=0, the instruction retires on that edge:
    - fetch_count increments.
    - instr_valid<=0.
    - pc<=branch_taken ? {branch_target[PC_W-1:2],2'b00} : pc+4.
    - Go to REQ.
- opcode is always instr[31:21] combinationally. All-zero instr decodes as a NOP class.
- branch_taken is sampled only in HOLD with stall=0; it is ignored in BOOT and REQ.
- imem_ack is ignored outside REQ, and imem_rdata is not captured then.
- pc+4 wraps modulo 2^PC_W. fetch_count wraps modulo 2^32.
- Simultaneous stall=1 and branch_taken=1 in HOLD: no redirect and no retire. The redirect must be re-presented when stall drops.

## Timing
- Ack sampled on edge N: instr_valid=1 and instr/opcode/pc_out updated after edge N.
- Minimum cadence with zero-wait memory is 2 cycles per instruction (REQ with ack, then HOLD with stall=0).
- First imem_req asserts one cycle after rst deasserts (BOOT cycle).
- Registered outputs: imem_req, imem_addr, instr, pc_out, instr_valid, fetch_count. opcode is a combinational slice of registered instr.
- Mid-fetch rst asserted:
  - imem_req drops asynchronously and the pending ack is discarded.
  - After release, fetch restarts at RESET_PC.
- Address change with imem_req=1 and no intervening ack is a violation, and never occurs.

## Test plan
- Reset/boot:
  - Stimulus: rst pulse, memory acks immediately.
  - Required: first imem_req in the 2nd cycle after release with imem_addr=0.
  - Required: instr_valid, fetch_count, and all other outputs at their reset values until then.
- Sequential fetch:
  - Stimulus: words F8400000, 8B020020, D2800000 at 0/4/8, zero-wait ack, stall=0.
  - Required: opcodes 7C2, 458, 694 in order, pc_out 0/4/8, instr_valid high every 2nd cycle, fetch_count=3 afterward.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles, then stall=1 for 4 cycles.
  - Required: imem_addr constant during the wait.
  - Required: instr, pc_out, and instr_valid=1 held during the stall; fetch_count unchanged until stall=0.
- Branch:
  - Stimulus: in HOLD at pc=8, branch_taken=1 with branch_target=0x103.
  - Required: next imem_addr=0x100.
  - Stimulus: branch_taken together with stall=1.
  - Required: no redirect, imem_req stays 0.
- Wrap-around:
  - Stimulus: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch.
  - Required: next imem_addr=0.
  - Stimulus: fetch_count preloaded via forced state to FFFFFFFF.
  - Required: fetch_count wraps to 0.
- Reset mid-fetch:
  - Stimulus: rst asserted while in REQ at pc=0x40, ack arrives during rst.
  - Required: imem_req falls without a clock edge; no capture; fetch restarts at RESET_PC.
